ps2_key_tracker: RTL

//  Upstream of the scancode/key RAM stage. Receives raw PS/2 keyboard frames,

---
 rtl/ps2_key_tracker.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Receives raw PS/2 keyboard frames, decodes make / break (F0) / extended
//   (E0) sequences, tracks the currently held key and buffers accepted key
//   presses in a small FIFO for the downstream key RAM writer.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   ps2_clk    raw PS/2 clock (asynchronous to clk)
//   ps2_data   raw PS/2 data  (asynchronous to clk)
//   out_valid  FIFO not empty
//   out_ready  consumer accepts the head entry this cycle
//   out_code   head entry scancode (prefix stripped), 0 when empty
//   out_ext    head entry followed an E0 prefix, 0 when empty
//   key_count  presses accepted into the FIFO, mod 256 (RAM write index)
//   overflow   sticky: a press was dropped because the FIFO was full
//   frame_err  one-cycle pulse on bad start/stop/parity or frame timeout
module ps2_key_tracker #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter bit REPEAT_EN   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic [7:0] key_count,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] BRK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } dec_state_e;

    // ------------------------------------------------------------------
    // Synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [2:0] ps2_clk_sync_q;
    logic [2:0] ps2_data_sync_q;
    logic       ps2_clk_prev_q;
    logic       ps2_fall;
    logic       ps2_bit;

    // NOTE: synchroniser flops reset to the idle-high line level so that
    // leaving reset with ps2_clk high never manufactures a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_sync_q  <= 3'b111;
            ps2_data_sync_q <= 3'b111;
            ps2_clk_prev_q  <= 1'b1;
        end else begin
            ps2_clk_sync_q  <= {ps2_clk_sync_q[1:0], ps2_clk};
            ps2_data_sync_q <= {ps2_data_sync_q[1:0], ps2_data};
            ps2_clk_prev_q  <= ps2_clk_sync_q[2];
        end
    end

    assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_sync_q[2];
    assign ps2_bit  = ps2_data_sync_q[2];

    // ------------------------------------------------------------------
    // Frame receiver
    // shift_q collects start, d[7:0], parity with the newest bit at [9];
    // after ten edges shift_q[0] is the start bit and [8:1] the data byte.
    // The stop bit is taken straight from the line on the 11th edge.
    // ------------------------------------------------------------------
    logic [3:0]    bit_cnt_q;
    logic [9:0]    shift_q;
    logic [TW-1:0] timer_q;
    logic          byte_valid_q;
    logic [7:0]    byte_q;
    logic          frame_err_q;
    logic          frame_ok;

    assign frame_ok = ~shift_q[0] & ps2_bit & (^shift_q[9:1]);

    // NOTE: byte_valid_q / frame_err_q default to 0 every cycle at the top of
    // the block, so they are single-cycle pulses without any clear logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q    <= 4'd0;
            shift_q      <= 10'd0;
            timer_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (ps2_fall) begin
                timer_q <= '0;
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q <= 4'd0;
                    if (frame_ok) begin
                        byte_valid_q <= 1'b1;
                        byte_q       <= shift_q[8:1];
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end else begin
                    shift_q   <= {ps2_bit, shift_q[9:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (bit_cnt_q != 4'd0) begin
                // Partial frame: abandon it once the line has been quiet too long.
                if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    timer_q     <= '0;
                    bit_cnt_q   <= 4'd0;
                    frame_err_q <= 1'b1;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end else begin
                timer_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder and held-key tracking
    // ------------------------------------------------------------------
    dec_state_e state_q;
    logic [8:0] held_q;
    logic       push_q;
    logic [8:0] push_data_q;
    logic [8:0] byte_key;
    logic       is_repeat;

    assign byte_key  = {(state_q == S_EXT) || (state_q == S_EXT_BRK), byte_q};
    assign is_repeat = (byte_key == held_q) && !REPEAT_EN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            held_q      <= 9'd0;
            push_q      <= 1'b0;
            push_data_q <= 9'd0;
        end else begin
            push_q <= 1'b0;
            if (byte_valid_q) begin
                case (state_q)
                    S_IDLE: begin
                        if (byte_q == BRK_PREFIX) begin
                            state_q <= S_BRK;
                        end else if (byte_q == EXT_PREFIX) begin
                            state_q <= S_EXT;
                        end else if (!is_repeat) begin
                            push_q      <= 1'b1;
                            push_data_q <= byte_key;
                            held_q      <= byte_key;
                        end
                    end
                    S_EXT: begin
                        if (byte_q == BRK_PREFIX) begin
                            state_q <= S_EXT_BRK;
                        end else begin
                            state_q <= S_IDLE;
                            if (!is_repeat) begin
                                push_q      <= 1'b1;
                                push_data_q <= byte_key;
                                held_q      <= byte_key;
                            end
                        end
                    end
                    S_BRK, S_EXT_BRK: begin
                        state_q <= S_IDLE;
                        if (byte_key == held_q) begin
                            held_q <= 9'd0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: pointers carry one extra wrap bit so full and empty are
    // told apart by the MSB alone.
    // ------------------------------------------------------------------
    logic [8:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [7:0]    key_count_q;
    logic          overflow_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          do_pop;
    logic          do_write;
    logic [8:0]    head_word;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop     = ~fifo_empty & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_write   = push_q & (~fifo_full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            key_count_q <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_q    <= wr_ptr_q + 1'b1;
                key_count_q <= key_count_q + 8'd1;
            end else if (push_q) begin
                overflow_q <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are only visible
    // through the head word, which is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
        end
    end

    always_comb begin
        head_word = 9'd0;
        if (!fifo_empty) begin
            head_word = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    assign out_valid = ~fifo_empty;
    assign out_code  = head_word[7:0];
    assign out_ext   = head_word[8];
    assign key_count = key_count_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
